// File: rtl/pong_engine_param.sv
// pong_engine_param
//   Parametrised, self-timed Pong game engine. Derives a frame tick from the
//   falling edge of vga_v_sync and runs the serve / play / point / game-over
//   state machine. Handles wall and paddle collisions, scoring and paddle
//   movement. Positions, scores and state are registered for the graphics
//   and seven-segment blocks.
//
//   Optional build macro: AI_RIGHT_EN
//     defined   -> right paddle tracks the ball centre; right_up/right_dn ignored
//     undefined -> right paddle follows right_up/right_dn
//
// Ports
//   ClkPort                  in   system clock
//   reset                    in   asynchronous, active-high reset
//   vga_v_sync               in   VGA vertical sync (active-low pulse)
//   start                    in   level; starts game from IDLE, returns OVER to IDLE
//   left_up/left_dn          in   left paddle controls (level)
//   right_up/right_dn        in   right paddle controls (level)
//   ball_x, ball_y           out  ball top-left corner
//   paddle_l_y, paddle_r_y   out  paddle top y
//   score_l, score_r         out  scores
//   state                    out  IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
//   frame_tick               out  one-cycle pulse per frame
//   game_over                out  high in OVER
module pong_engine_param #(
  parameter int POS_W         = 10,
  parameter int CANVAS_TOP    = 50,
  parameter int CANVAS_BOTTOM = 450,
  parameter int CANVAS_LEFT   = 50,
  parameter int CANVAS_RIGHT  = 600,
  parameter int BALL_SIZE     = 10,
  parameter int PADDLE_OFFSET = 20,
  parameter int PADDLE_HEIGHT = 50,
  parameter int PADDLE_WIDTH  = 10,
  parameter int PADDLE_STEP   = 4,
  parameter int BALL_STEP     = 2,
  parameter int SCORE_LIMIT   = 9,
  parameter int SERVE_FRAMES  = 60
) (
  input  logic             ClkPort,
  input  logic             reset,
  input  logic             vga_v_sync,
  input  logic             start,
  input  logic             left_up,
  input  logic             left_dn,
  input  logic             right_up,
  input  logic             right_dn,
  output logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] ball_y,
  output logic [POS_W-1:0] paddle_l_y,
  output logic [POS_W-1:0] paddle_r_y,
  output logic [3:0]       score_l,
  output logic [3:0]       score_r,
  output logic [2:0]       state,
  output logic             frame_tick,
  output logic             game_over
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int BALL_CX    = (CANVAS_LEFT + CANVAS_RIGHT - BALL_SIZE) / 2;
  localparam int BALL_CY    = (CANVAS_TOP + CANVAS_BOTTOM - BALL_SIZE) / 2;
  localparam int PADDLE_C   = (CANVAS_TOP + CANVAS_BOTTOM - PADDLE_HEIGHT) / 2;
  localparam int PADDLE_MIN = CANVAS_TOP;
  localparam int PADDLE_MAX = CANVAS_BOTTOM - PADDLE_HEIGHT;
  localparam int LEFT_FACE  = CANVAS_LEFT + PADDLE_OFFSET + PADDLE_WIDTH;
  localparam int RIGHT_FACE = CANVAS_RIGHT - PADDLE_OFFSET - PADDLE_WIDTH;
  localparam int CNT_W      = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

  localparam logic [POS_W-1:0] BALL_CX_P  = POS_W'(BALL_CX);
  localparam logic [POS_W-1:0] BALL_CY_P  = POS_W'(BALL_CY);
  localparam logic [POS_W-1:0] PADDLE_C_P = POS_W'(PADDLE_C);
  localparam logic [3:0]       LIMIT      = 4'(SCORE_LIMIT);
  localparam logic [CNT_W-1:0] SERVE_INIT = CNT_W'(SERVE_FRAMES);

  state_t           st;
  logic             sync_a, sync_b, sync_c;
  logic             serve_right;
  logic [CNT_W-1:0] serve_cnt;
  logic             dx_neg, dy_neg;

  // Paddle arithmetic is done in 32-bit signed int so a step past either
  // edge cannot wrap before the clamp.
  int               pl_move, pr_move;
  logic [POS_W-1:0] pl_next, pr_next;
`ifdef AI_RIGHT_EN
  int               ai_diff;
`endif

  int               nx, ny;
  logic             overlap_l, overlap_r;
  logic [POS_W-1:0] play_x, play_y;
  logic             play_dx_neg, play_dy_neg;
  logic             miss_l, miss_r;

  assign state = st;

  function automatic logic [POS_W-1:0] clamp_paddle(input int v);
    if (v < PADDLE_MIN)      return POS_W'(PADDLE_MIN);
    else if (v > PADDLE_MAX) return POS_W'(PADDLE_MAX);
    else                     return POS_W'(v);
  endfunction

  function automatic logic [3:0] bump_score(input logic [3:0] s);
    return (s >= LIMIT) ? s : s + 4'd1;
  endfunction

  // Candidate paddle positions for this frame; only committed in moving states.
  always_comb begin
    pl_move = int'(paddle_l_y);
    if (left_up && !left_dn)      pl_move = pl_move - PADDLE_STEP;
    else if (left_dn && !left_up) pl_move = pl_move + PADDLE_STEP;

    pr_move = int'(paddle_r_y);
`ifdef AI_RIGHT_EN
    // Step toward lining up paddle centre with ball centre; dead band of
    // one step avoids dithering around the target.
    ai_diff = (int'(ball_y) + BALL_SIZE / 2) - (int'(paddle_r_y) + PADDLE_HEIGHT / 2);
    if (ai_diff >= PADDLE_STEP)       pr_move = pr_move + PADDLE_STEP;
    else if (ai_diff <= -PADDLE_STEP) pr_move = pr_move - PADDLE_STEP;
`else
    if (right_up && !right_dn)      pr_move = pr_move - PADDLE_STEP;
    else if (right_dn && !right_up) pr_move = pr_move + PADDLE_STEP;
`endif

    pl_next = clamp_paddle(pl_move);
    pr_next = clamp_paddle(pr_move);
  end

  // Ball motion for one PLAY frame. Paddle overlap uses the current ball and
  // paddle rows; a paddle hit takes priority over a miss on the same side.
  always_comb begin
    nx = int'(ball_x) + (dx_neg ? -BALL_STEP : BALL_STEP);
    ny = int'(ball_y) + (dy_neg ? -BALL_STEP : BALL_STEP);

    overlap_l = (int'(ball_y) + BALL_SIZE > int'(paddle_l_y)) &&
                (int'(ball_y) < int'(paddle_l_y) + PADDLE_HEIGHT);
    overlap_r = (int'(ball_y) + BALL_SIZE > int'(paddle_r_y)) &&
                (int'(ball_y) < int'(paddle_r_y) + PADDLE_HEIGHT);

    play_y      = POS_W'(ny);
    play_dy_neg = dy_neg;
    if (ny <= CANVAS_TOP) begin
      play_y      = POS_W'(CANVAS_TOP);
      play_dy_neg = 1'b0;
    end else if (ny + BALL_SIZE >= CANVAS_BOTTOM) begin
      play_y      = POS_W'(CANVAS_BOTTOM - BALL_SIZE);
      play_dy_neg = 1'b1;
    end

    play_x      = POS_W'(nx);
    play_dx_neg = dx_neg;
    miss_l      = 1'b0;
    miss_r      = 1'b0;
    if (dx_neg && nx <= LEFT_FACE && overlap_l) begin
      play_x      = POS_W'(LEFT_FACE);
      play_dx_neg = 1'b0;
    end else if (!dx_neg && nx + BALL_SIZE >= RIGHT_FACE && overlap_r) begin
      play_x      = POS_W'(RIGHT_FACE - BALL_SIZE);
      play_dx_neg = 1'b1;
    end else if (nx <= CANVAS_LEFT) begin
      miss_l = 1'b1;
    end else if (nx + BALL_SIZE >= CANVAS_RIGHT) begin
      miss_r = 1'b1;
    end
  end

  // Sync chain resets high (sync idle level) so leaving reset never looks
  // like a falling edge. All game state advances only in the frame_tick cycle.
  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      sync_a      <= 1'b1;
      sync_b      <= 1'b1;
      sync_c      <= 1'b1;
      frame_tick  <= 1'b0;
      st          <= ST_IDLE;
      ball_x      <= BALL_CX_P;
      ball_y      <= BALL_CY_P;
      paddle_l_y  <= PADDLE_C_P;
      paddle_r_y  <= PADDLE_C_P;
      score_l     <= 4'd0;
      score_r     <= 4'd0;
      serve_right <= 1'b1;
      serve_cnt   <= '0;
      dx_neg      <= 1'b0;
      dy_neg      <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      sync_a     <= vga_v_sync;
      sync_b     <= sync_a;
      sync_c     <= sync_b;
      frame_tick <= sync_c & ~sync_b;

      if (frame_tick) begin
        if (st == ST_SERVE || st == ST_PLAY || st == ST_POINT) begin
          paddle_l_y <= pl_next;
          paddle_r_y <= pr_next;
        end

        case (st)
          ST_IDLE: begin
            ball_x <= BALL_CX_P;
            ball_y <= BALL_CY_P;
            if (start) begin
              st        <= ST_SERVE;
              serve_cnt <= SERVE_INIT;
            end
          end

          ST_SERVE: begin
            ball_x <= BALL_CX_P;
            ball_y <= BALL_CY_P;
            if (serve_cnt <= CNT_W'(1)) begin
              serve_cnt <= '0;
              dx_neg    <= ~serve_right;
              dy_neg    <= 1'b0;
              st        <= ST_PLAY;
            end else begin
              serve_cnt <= serve_cnt - CNT_W'(1);
            end
          end

          ST_PLAY: begin
            ball_x <= play_x;
            ball_y <= play_y;
            dx_neg <= play_dx_neg;
            dy_neg <= play_dy_neg;
            // The player who just scored receives the next serve.
            if (miss_l) begin
              score_r     <= bump_score(score_r);
              serve_right <= 1'b1;
              st          <= ST_POINT;
            end else if (miss_r) begin
              score_l     <= bump_score(score_l);
              serve_right <= 1'b0;
              st          <= ST_POINT;
            end
          end

          ST_POINT: begin
            if (score_l == LIMIT || score_r == LIMIT) begin
              st        <= ST_OVER;
              game_over <= 1'b1;
            end else begin
              ball_x    <= BALL_CX_P;
              ball_y    <= BALL_CY_P;
              serve_cnt <= SERVE_INIT;
              st        <= ST_SERVE;
            end
          end

          ST_OVER: begin
            if (start) begin
              st          <= ST_IDLE;
              game_over   <= 1'b0;
              ball_x      <= BALL_CX_P;
              ball_y      <= BALL_CY_P;
              paddle_l_y  <= PADDLE_C_P;
              paddle_r_y  <= PADDLE_C_P;
              score_l     <= 4'd0;
              score_r     <= 4'd0;
              serve_right <= 1'b1;
            end
          end

          default: begin
            st        <= ST_IDLE;
            game_over <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
